// File: rtl/boolean_sweep_ctrl_if.sv
// rtl/boolean_sweep_ctrl_if.sv - control, stimulus and result bundle for the boolean sweep sequencer
interface boolean_sweep_ctrl_if #(
  parameter int N_IN = 3
);
  logic                   start;
  logic [(1<<N_IN)-1:0]   expected;
  logic                   dut_y;
  logic [N_IN-1:0]        vec_out;
  logic                   busy;
  logic                   done;
  logic [(1<<N_IN)-1:0]   truth;
  logic                   pass;
  logic [N_IN:0]          mismatch_cnt;
  logic [N_IN-1:0]        first_bad;
  logic                   first_bad_vld;

  // Sequencer side: consumes start/expected and the unit output, drives vectors and results
  modport master (
    input  start, expected, dut_y,
    output vec_out, busy, done, truth, pass, mismatch_cnt, first_bad, first_bad_vld
  );

  // Host/unit side: mirror of the sequencer view
  modport slave (
    output start, expected, dut_y,
    input  vec_out, busy, done, truth, pass, mismatch_cnt, first_bad, first_bad_vld
  );
endinterface

// File: rtl/boolean_sweep_ctrl.sv
// rtl/boolean_sweep_ctrl.sv - exhaustive truth-table sweep and self-check of an N-input boolean unit
module boolean_sweep_ctrl #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  boolean_sweep_ctrl_if.master bus
);

  localparam int W  = 1 << N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] VEC_ONE     = N_IN'(1);
  localparam logic [N_IN:0]   MIS_ONE     = (N_IN+1)'(1);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    exp_q;
  logic [W-1:0]    truth_upd;
  logic            last_vec;
  logic            settle_done;
  logic            bit_bad;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the sample-time view of the truth table and compare
  always_comb begin
    state_nxt   = state;
    last_vec    = (bus.vec_out == LAST_VEC);
    settle_done = (cnt == SETTLE_LAST);
    bit_bad     = (bus.dut_y != exp_q[bus.vec_out]);
    truth_upd   = bus.truth;
    truth_upd[bus.vec_out] = bus.dut_y;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_WAIT;
      S_WAIT:   if (settle_done) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_vec ? S_DONE : S_WAIT;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Vector walk, settle counter, capture and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vec_out       <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.truth         <= '0;
      bus.pass          <= 1'b0;
      bus.mismatch_cnt  <= '0;
      bus.first_bad     <= '0;
      bus.first_bad_vld <= 1'b0;
      cnt               <= '0;
      exp_q             <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            exp_q             <= bus.expected;
            bus.truth         <= '0;
            bus.mismatch_cnt  <= '0;
            bus.first_bad     <= '0;
            bus.first_bad_vld <= 1'b0;
            bus.pass          <= 1'b0;
            bus.vec_out       <= '0;
            bus.busy          <= 1'b1;
            cnt               <= '0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CNT_ONE;
        end
        S_SAMPLE: begin
          bus.truth <= truth_upd;
          if (bit_bad) begin
            bus.mismatch_cnt <= bus.mismatch_cnt + MIS_ONE;
            if (!bus.first_bad_vld) begin
              bus.first_bad     <= bus.vec_out;
              bus.first_bad_vld <= 1'b1;
            end
          end
          if (last_vec) begin
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (truth_upd == exp_q);
          end else begin
            bus.vec_out <= bus.vec_out + VEC_ONE;
            cnt         <= '0;
          end
        end
        S_DONE: begin
          bus.done <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// tb/tb_boolean_sweep_ctrl.sv - randomized and directed self-check of boolean_sweep_ctrl
module tb_boolean_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       start_r = 1'b0;
  logic [7:0] exp_r = 8'h00;
  logic [7:0] unit_tt = 8'hEA;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  boolean_sweep_ctrl_if #(.N_IN(3)) ifa ();
  boolean_sweep_ctrl_if #(.N_IN(3)) ifb ();

  assign ifa.start    = start_r & ~sel;
  assign ifb.start    = start_r & sel;
  assign ifa.expected = exp_r;
  assign ifb.expected = exp_r;
  assign ifa.dut_y    = unit_tt[ifa.vec_out];
  assign ifb.dut_y    = unit_tt[ifb.vec_out];

  boolean_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  boolean_sweep_ctrl #(.N_IN(3), .SETTLE(3)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  logic [2:0] m_vec;
  logic       m_busy, m_done, m_pass, m_vld;
  logic [7:0] m_truth;
  logic [3:0] m_mis;
  logic [2:0] m_fb;

  assign m_vec   = sel ? ifb.vec_out       : ifa.vec_out;
  assign m_busy  = sel ? ifb.busy          : ifa.busy;
  assign m_done  = sel ? ifb.done          : ifa.done;
  assign m_pass  = sel ? ifb.pass          : ifa.pass;
  assign m_vld   = sel ? ifb.first_bad_vld : ifa.first_bad_vld;
  assign m_truth = sel ? ifb.truth         : ifa.truth;
  assign m_mis   = sel ? ifb.mismatch_cnt  : ifa.mismatch_cnt;
  assign m_fb    = sel ? ifb.first_bad     : ifa.first_bad;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {m_busy, m_done, m_vec}, 5'b0);
    chk({tag, "_res"}, {m_truth, m_pass, m_mis, m_fb, m_vld}, 17'b0);
  endtask

  // One complete sweep on the selected instance, checked against the table-level model:
  // truth is the unit's table, mismatches are the set bits of unit^expected.
  task automatic sweep(input bit s, input logic [7:0] u, input logic [7:0] e,
                       input int mid_c, input bit done_start, input int rst_c);
    int st;
    int t;
    int fb;
    logic [7:0] diff;
    st   = s ? 3 : 1;
    t    = 8 * (st + 1);
    diff = u ^ e;
    fb   = 0;
    for (int i = 7; i >= 0; i--) if (diff[i]) fb = i;
    sel     = s;
    unit_tt = u;
    exp_r   = e;
    start_r = 1'b1;
    @(negedge clk);
    for (int c = 0; c < t; c++) begin
      chk("walk", {m_busy, m_done, m_vec}, {2'b10, 3'(c / (st + 1))});
      if (c == mid_c) begin
        start_r = 1'b1;
        exp_r   = 8'h00;
      end else begin
        start_r = 1'b0;
      end
      if (c == rst_c) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("mid_rst");
        return;
      end
      @(negedge clk);
    end
    chk("done_ctl", {m_busy, m_done, m_vec}, {2'b01, 3'd7});
    chk("truth", m_truth, u);
    chk("pass", m_pass, (diff == 8'h00));
    chk("mismatch_cnt", m_mis, $countones(diff));
    chk("first_bad_vld", m_vld, (diff != 8'h00));
    chk("first_bad", m_fb, fb);
    start_r = done_start;
    @(negedge clk);
    start_r = 1'b0;
    chk("post_done", {m_busy, m_done, m_vec, m_truth, m_pass}, {2'b00, 3'd7, u, (diff == 8'h00)});
    @(negedge clk);
    chk("idle_hold", {m_busy, m_done, m_mis}, {2'b00, 4'($countones(diff))});
  endtask

  initial begin
    int         dones;
    bit         rs;
    int         mode;
    logic [7:0] ru;
    logic [7:0] re;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    chk_reset_vals("reset_a");
    sel = 1'b1;
    chk_reset_vals("reset_b");
    rst = 1'b0;
    @(negedge clk);

    sweep(1'b0, 8'hEA, 8'hEA, -1, 1'b0, -1);
    sweep(1'b0, 8'hEA, 8'h2B, -1, 1'b0, -1);
    sweep(1'b0, 8'hEA, 8'h6A, -1, 1'b0, -1);
    sweep(1'b1, 8'hEA, 8'hEA, -1, 1'b0, -1);
    sweep(1'b0, 8'hEA, 8'hEA, 5, 1'b1, -1);

    sweep(1'b0, 8'hEA, 8'hEA, -1, 1'b0, 9);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_done) dones++;
      @(negedge clk);
    end
    chk("no_done_after_rst", dones, 0);
    chk_reset_vals("idle_after_rst");
    sweep(1'b0, 8'hEA, 8'hEA, -1, 1'b0, -1);

    for (int n = 0; n < 16; n++) begin
      rs   = 1'($urandom_range(0, 1));
      ru   = 8'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) re = ru;
      else if (mode == 1) re = ru ^ (8'h01 << $urandom_range(0, 7));
      else re = 8'($urandom);
      sweep(rs, ru, re, -1, 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
